// File: rtl/ysyx_25040111_lsu_pkg.sv
// Shared LSU encodings: FSM states, access-size codes and exception cause codes.
// Also holds the alignment rule shared by the FSM.
package ysyx_25040111_lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RADDR,
        S_RDATA,
        S_WREQ,
        S_WRESP,
        S_DONE
    } lsu_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return ((size == SZ_HALF) && lo[0]) || ((size == SZ_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/ysyx_25040111_lsu_align.sv
// Byte-lane steering for the LSU: store data/strobe placement and load
// right-alignment with zero or sign extension.
module ysyx_25040111_lsu_align
    import ysyx_25040111_lsu_pkg::*;
(
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] ldata_o
);

    logic [4:0]  shamt;
    logic [31:0] rshift;
    logic [3:0]  strb_base;

    assign shamt   = {offset_i, 3'b000};
    assign wdata_o = wdata_i << shamt;
    assign rshift  = rdata_i >> shamt;
    assign wstrb_o = strb_base << offset_i;

    always_comb begin
        strb_base = 4'b1111;
        ldata_o   = rshift;
        case (size_i)
            SZ_BYTE: begin
                strb_base = 4'b0001;
                ldata_o   = {{24{sign_i & rshift[7]}}, rshift[7:0]};
            end
            SZ_HALF: begin
                strb_base = 4'b0011;
                ldata_o   = {{16{sign_i & rshift[15]}}, rshift[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_25040111_lsu.sv
// Load/store and write-back unit: takes one retired-operation record, performs
// the AXI4-Lite data access if needed, then writes GPR/CSR and pulses abt_finish.
module ysyx_25040111_lsu
    import ysyx_25040111_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                abt_valid,
    output logic                abt_ready,
    input  logic                abt_men,
    input  logic                abt_write,
    input  logic [ADDR_W-1:0]   abt_addr,
    input  logic [DATA_W-1:0]   abt_wdata,
    input  logic [1:0]          abt_mask,
    input  logic                abt_rsign,
    input  logic [4:0]          abt_ard,
    input  logic [31:0]         abt_rd,
    input  logic                abt_gen,
    input  logic [11:0]         abt_acsr,
    input  logic [31:0]         abt_csr,
    input  logic                abt_sen,
    input  logic [31:0]         abt_pc,
    input  logic                erri,
    input  logic [3:0]          errtpi,
    output logic                abt_finish,
    output logic [4:0]          abt_frd,
    output logic                gpr_wen,
    output logic [4:0]          gpr_waddr,
    output logic [31:0]         gpr_wdata,
    output logic                csr_wen,
    output logic [11:0]         csr_waddr,
    output logic [31:0]         csr_wdata,
    output logic [31:0]         retire_pc,
    output logic                erro,
    output logic [3:0]          errtpo,
    output logic                mem_arvalid,
    input  logic                mem_arready,
    output logic [ADDR_W-1:0]   mem_araddr,
    input  logic                mem_rvalid,
    output logic                mem_rready,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic [1:0]          mem_rresp,
    output logic                mem_awvalid,
    input  logic                mem_awready,
    output logic [ADDR_W-1:0]   mem_awaddr,
    output logic                mem_wvalid,
    input  logic                mem_wready,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_bvalid,
    output logic                mem_bready,
    input  logic [1:0]          mem_bresp
);

    lsu_state_e state_q, state_d;

    logic              write_q, rsign_q, gen_q, sen_q, erri_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        mask_q;
    logic [4:0]        ard_q;
    logic [31:0]       rd_q, csr_q, pc_q;
    logic [11:0]       acsr_q;
    logic [3:0]        errtpi_q;
    logic              aw_done_q, w_done_q;

    logic              finish_q, gpr_wen_q, csr_wen_q, erro_q;
    logic [4:0]        frd_q;
    logic [31:0]       gpr_wdata_q, csr_wdata_q, pc_out_q;
    logic [11:0]       csr_waddr_q;
    logic [3:0]        errtpo_q;

    logic              idle, enter_done, fault, use_load, done_err, aw_ok, w_ok;
    logic [3:0]        fault_tp;
    logic [31:0]       al_wdata, al_ldata;
    logic [3:0]        al_wstrb;

    // Retire fields come from the live inputs when a record skips the bus
    // straight out of IDLE, otherwise from the captured copy.
    logic              c_gen, c_sen, c_erri;
    logic [4:0]        c_ard;
    logic [31:0]       c_rd, c_csr, c_pc;
    logic [11:0]       c_acsr;
    logic [3:0]        c_errtpi;

    assign idle     = (state_q == S_IDLE);
    assign c_gen    = idle ? abt_gen   : gen_q;
    assign c_sen    = idle ? abt_sen   : sen_q;
    assign c_erri   = idle ? erri      : erri_q;
    assign c_ard    = idle ? abt_ard   : ard_q;
    assign c_rd     = idle ? abt_rd    : rd_q;
    assign c_csr    = idle ? abt_csr   : csr_q;
    assign c_pc     = idle ? abt_pc    : pc_q;
    assign c_acsr   = idle ? abt_acsr  : acsr_q;
    assign c_errtpi = idle ? errtpi    : errtpi_q;
    assign done_err = c_erri | fault;

    ysyx_25040111_lsu_align u_align (
        .offset_i (addr_q[1:0]),
        .size_i   (mask_q),
        .sign_i   (rsign_q),
        .wdata_i  (wdata_q),
        .rdata_i  (mem_rdata),
        .wdata_o  (al_wdata),
        .wstrb_o  (al_wstrb),
        .ldata_o  (al_ldata)
    );

    assign abt_ready   = idle;
    assign mem_arvalid = (state_q == S_RADDR);
    assign mem_araddr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_rready  = (state_q == S_RDATA);
    assign mem_awvalid = (state_q == S_WREQ) & ~aw_done_q;
    assign mem_awaddr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wvalid  = (state_q == S_WREQ) & ~w_done_q;
    assign mem_wdata   = (state_q == S_WREQ) ? al_wdata : '0;
    assign mem_wstrb   = (state_q == S_WREQ) ? al_wstrb : '0;
    assign mem_bready  = (state_q == S_WRESP);
    assign aw_ok       = aw_done_q | (mem_awvalid & mem_awready);
    assign w_ok        = w_done_q  | (mem_wvalid  & mem_wready);

    always_comb begin
        state_d    = state_q;
        enter_done = 1'b0;
        fault      = 1'b0;
        fault_tp   = 4'd0;
        use_load   = 1'b0;
        case (state_q)
            S_IDLE: if (abt_valid) begin
                if (erri || !abt_men || misaligned(abt_mask, abt_addr[1:0])) begin
                    state_d    = S_DONE;
                    enter_done = 1'b1;
                    if (!erri && abt_men) begin
                        fault    = 1'b1;
                        fault_tp = abt_write ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
                    end
                end else begin
                    state_d = abt_write ? S_WREQ : S_RADDR;
                end
            end
            S_RADDR: if (mem_arready) state_d = S_RDATA;
            S_RDATA: if (mem_rvalid) begin
                state_d    = S_DONE;
                enter_done = 1'b1;
                use_load   = 1'b1;
                fault      = (mem_rresp != 2'b00);
                fault_tp   = CAUSE_LD_FAULT;
            end
            S_WREQ: if (aw_ok && w_ok) state_d = S_WRESP;
            S_WRESP: if (mem_bvalid) begin
                state_d    = S_DONE;
                enter_done = 1'b1;
                fault      = (mem_bresp != 2'b00);
                fault_tp   = CAUSE_ST_FAULT;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q != S_WREQ) begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else begin
                if (mem_awvalid && mem_awready) aw_done_q <= 1'b1;
                if (mem_wvalid && mem_wready)   w_done_q  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_q  <= 1'b0;  rsign_q <= 1'b0;  gen_q  <= 1'b0;
            sen_q    <= 1'b0;  erri_q  <= 1'b0;  addr_q <= '0;
            wdata_q  <= '0;    mask_q  <= '0;    ard_q  <= '0;
            rd_q     <= '0;    csr_q   <= '0;    pc_q   <= '0;
            acsr_q   <= '0;    errtpi_q <= '0;
        end else if (abt_valid && idle) begin
            write_q  <= abt_write;  rsign_q <= abt_rsign;  gen_q  <= abt_gen;
            sen_q    <= abt_sen;    erri_q  <= erri;       addr_q <= abt_addr;
            wdata_q  <= abt_wdata;  mask_q  <= abt_mask;   ard_q  <= abt_ard;
            rd_q     <= abt_rd;     csr_q   <= abt_csr;    pc_q   <= abt_pc;
            acsr_q   <= abt_acsr;   errtpi_q <= errtpi;
        end
    end

    // Retire outputs are loaded on the edge that enters DONE, so the pulses
    // are register-driven and exactly one cycle wide.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            finish_q    <= 1'b0;  gpr_wen_q   <= 1'b0;  csr_wen_q <= 1'b0;
            erro_q      <= 1'b0;  frd_q       <= '0;    errtpo_q  <= '0;
            gpr_wdata_q <= '0;    csr_wdata_q <= '0;    pc_out_q  <= '0;
            csr_waddr_q <= '0;
        end else begin
            finish_q  <= enter_done;
            gpr_wen_q <= enter_done & c_gen & ~done_err & (c_ard != 5'd0);
            csr_wen_q <= enter_done & c_sen & ~fault;
            if (enter_done) begin
                frd_q       <= c_ard;
                pc_out_q    <= c_pc;
                erro_q      <= done_err;
                errtpo_q    <= fault ? fault_tp : (c_erri ? c_errtpi : 4'd0);
                gpr_wdata_q <= use_load ? al_ldata : c_rd;
                csr_waddr_q <= c_acsr;
                csr_wdata_q <= c_csr;
            end
        end
    end

    assign abt_finish = finish_q;
    assign abt_frd    = frd_q;
    assign gpr_wen    = gpr_wen_q;
    assign gpr_waddr  = frd_q;
    assign gpr_wdata  = gpr_wdata_q;
    assign csr_wen    = csr_wen_q;
    assign csr_waddr  = csr_waddr_q;
    assign csr_wdata  = csr_wdata_q;
    assign retire_pc  = pc_out_q;
    assign erro       = erro_q;
    assign errtpo     = errtpo_q;

endmodule
